wb_native_bridge: RTL
=====================

// Module: wb_native_bridge
// PURPOSE
//   Wishbone slave that lets the management SoC reach the PicoSoC native memory bus (SRAM, UART,
//   SPI-flash config) for program load and debug. It drives a second native-bus master port
//   into simple_interconnect. It converts each Wishbone cycle into one native valid/ready
//   transfer, with address-window decode, a timeout watchdog and a sticky error flag.
// PARAMETERS
//   BASE_ADDR  32'h3000_0000  Wishbone window base; hit when (wbs_adr_i & ADDR_MASK) == BASE_ADDR
//   ADDR_MASK  32'hFF00_0000  window mask; native address = wbs_adr_i & ~ADDR_MASK, bits[1:0] forced 0
//   TIMEOUT    8'd255         cycles in BUSY without mem_ready before the bridge aborts
// PORTS
//   wb_clk_i     in   1   single clock for the whole block
//   wb_rst_i     in   1   synchronous reset, active high
//   wbs_stb_i    in   1   Wishbone strobe
//   wbs_cyc_i    in   1   Wishbone cycle
//   wbs_we_i     in   1   1 = write
//   wbs_sel_i    in   4   byte selects
//   wbs_dat_i    in   32  write data
//   wbs_adr_i    in   32  byte address
//   wbs_ack_o    out  1   single-cycle acknowledge
//   wbs_dat_o    out  32  read data, valid while wbs_ack_o=1
//   mem_valid    out  1   native request
//   mem_instr    out  1   tied 0
//   mem_addr     out  32  native word address
//   mem_wdata    out  32  native write data
//   mem_wstrb    out  4   byte strobes; 0 = read
//   mem_ready    in   1   native completion
//   mem_rdata    in   32  native read data, valid with mem_ready
//   timeout_flag out  1   sticky: a transfer timed out since the last reset
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; timeout counter 0.
//   FSM IDLE -> BUSY -> ACK -> IDLE. All outputs are registered.
//   IDLE: a hit (cyc & stb & window match) is sampled.
//     - Latch mem_addr, mem_wdata=wbs_dat_i, mem_wstrb = wbs_we_i ? wbs_sel_i : 4'h0.
//     - mem_valid=1, counter=0, go to BUSY.
//     - Miss: ignored, no ack, state unchanged.
//   Write with wbs_sel_i=0: no native access; ack next cycle with wbs_dat_o=0; go to ACK.
//   BUSY: mem_valid, mem_addr, mem_wdata and mem_wstrb are held stable until mem_ready is sampled 1.
//   On mem_ready: mem_valid<=0; wbs_ack_o<=1; wbs_dat_o <= read ? mem_rdata : 0; go to ACK.
//   Min latency: stb seen at edge N, mem_valid high after N, ack high after N+1 (ready at N+1).
//   Timeout: counter increments each BUSY cycle without ready.
//     - When counter==TIMEOUT: mem_valid<=0, wbs_ack_o<=1, wbs_dat_o<=32'hDEAD_BEEF, timeout_flag<=1.
//     - Go to ACK. The flag clears only on wb_rst_i.
//   cyc dropped during BUSY:
//     - The native transfer still runs to ready or timeout (it cannot be aborted).
//     - The ack is suppressed and the state returns to IDLE; wbs_dat_o stays 0.
//   mem_ready and timeout in the same cycle: ready wins, normal data, flag not set.
//   ACK: wbs_ack_o<=0, wbs_dat_o<=0, go to IDLE.
//     - The ack cycle is never re-sampled as a new request, so a stb still high there is not a new hit.
//   mem_ready while IDLE or ACK: ignored.
//   wb_rst_i mid-transfer: mem_valid and wbs_ack_o are 0 after that edge; no partial ack.
//   Back-to-back cycles: the next request is sampled no earlier than the cycle after ACK.
// TESTING
//   Read 0x3000_0100, mem_ready 1 cycle after valid with rdata=0x1234_5678
//     -> mem_addr=0x0000_0100, wstrb=0, ack 2 cycles after stb, dat_o=0x1234_5678.
//   Write 0x3000_0004, sel=4'b0110, dat=0xA5A5_A5A5, ready after 3 cycles
//     -> valid held 3 cycles with stable addr/data, wstrb=0110, single ack, dat_o=0.
//   Access 0x2000_0000 -> no mem_valid, no ack for 300 cycles.
//   Read with mem_ready never asserted -> valid drops after 255 BUSY cycles, ack with 0xDEAD_BEEF,
//     timeout_flag=1 and still 1 after the next good transfer.
//   cyc deasserted 2 cycles into BUSY, ready on cycle 5 -> valid drops, no ack, next request accepted.
//   wb_rst_i pulsed during BUSY -> mem_valid=0, ack=0, flag=0 next cycle; a following read completes normally.

Source files
------------

// File: rtl/wb_native_bridge.sv
module wb_native_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFF00_0000,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACK
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        flag_q, flag_d;

  logic        hit;
  logic        abort;

  assign hit = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    ack_d   = ack_q;
    dat_d   = dat_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    flag_d  = flag_q;
    // cyc may fall on any BUSY cycle; remember it so the eventual completion drops the ack
    abort   = drop_q | ~wbs_cyc_i;

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          if (wbs_we_i && (wbs_sel_i == 4'h0)) begin
            ack_d   = 1'b1;
            dat_d   = '0;
            state_d = S_ACK;
          end else begin
            addr_d  = wbs_adr_i & ~ADDR_MASK & 32'hFFFF_FFFC;
            wdata_d = wbs_dat_i;
            wstrb_d = wbs_we_i ? wbs_sel_i : 4'h0;
            valid_d = 1'b1;
            cnt_d   = '0;
            drop_d  = 1'b0;
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        drop_d = abort;
        if (mem_ready) begin
          valid_d = 1'b0;
          if (abort) begin
            state_d = S_IDLE;
          end else begin
            ack_d   = 1'b1;
            dat_d   = (wstrb_q == 4'h0) ? mem_rdata : '0;
            state_d = S_ACK;
          end
        end else if (cnt_q == TIMEOUT) begin
          valid_d = 1'b0;
          flag_d  = 1'b1;
          if (abort) begin
            state_d = S_IDLE;
          end else begin
            ack_d   = 1'b1;
            dat_d   = 32'hDEAD_BEEF;
            state_d = S_ACK;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_ACK: begin
        ack_d   = 1'b0;
        dat_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      flag_q  <= flag_d;
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign mem_valid    = valid_q;
  assign mem_instr    = 1'b0;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wstrb    = wstrb_q;
  assign timeout_flag = flag_q;

endmodule
